// File: rtl/result_packer.sv
// result_packer: packs quantized activation beats (2/4/8-bit lanes) into
// full-width output-feature-map SRAM words and issues the write address,
// write enable, word count, busy and layer-done signals.
module result_packer #(
  parameter int LANES      = 16,
  parameter int LANE_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          layer_start,
  input  logic [1:0]                    i_precision,
  input  logic [ADDR_WIDTH-1:0]         base_addr,
  input  logic                          i_Vld,
  input  logic [LANES*LANE_WIDTH-1:0]   i_Data,
  input  logic                          layer_end,
  output logic                          o_WrEn,
  output logic [ADDR_WIDTH-1:0]         o_WrAddr,
  output logic [LANES*LANE_WIDTH-1:0]   o_WrData,
  output logic [ADDR_WIDTH:0]           o_WordCnt,
  output logic                          o_Busy,
  output logic                          o_Done
);

  localparam int W     = LANES * LANE_WIDTH;
  localparam int SLOT2 = 2 * LANES;   // bits one 2-bit beat occupies
  localparam int SLOT4 = 4 * LANES;   // bits one 4-bit beat occupies

  // Internal precision code: 0 = 2b, 1 = 4b, 2 = 8b
  localparam logic [1:0] PREC_2B = 2'd0;
  localparam logic [1:0] PREC_4B = 2'd1;
  localparam logic [1:0] PREC_8B = 2'd2;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              prec_q, prec_d;
  logic [W-1:0]            acc_q, acc_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [W-1:0]            wr_data_q, wr_data_d;
  logic [ADDR_WIDTH:0]     word_cnt_q, word_cnt_d;
  logic                    done_q, done_d;

  logic [SLOT2-1:0]        pack2;
  logic [SLOT4-1:0]        pack4;
  logic [W-1:0]            pack8;
  logic [W-1:0]            beat_word;
  logic [W-1:0]            acc_sum;
  logic [2:0]              cnt_after;
  logic [2:0]              beats_per_word;
  logic                    do_write;

  // Gather the low p bits of every lane into a dense per-precision vector
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign pack2[gi*2 +: 2] = i_Data[gi*LANE_WIDTH +: 2];
    assign pack4[gi*4 +: 4] = i_Data[gi*LANE_WIDTH +: 4];
    assign pack8[gi*LANE_WIDTH +: LANE_WIDTH] = i_Data[gi*LANE_WIDTH +: LANE_WIDTH];
  end

  // Place the incoming beat into its slot of the word being assembled
  always_comb begin
    beat_word      = pack8;
    beats_per_word = 3'd1;
    case (prec_q)
      PREC_2B: begin
        beat_word      = W'(pack2) << (cnt_q * SLOT2);
        beats_per_word = 3'd4;
      end
      PREC_4B: begin
        beat_word      = W'(pack4) << (cnt_q * SLOT4);
        beats_per_word = 3'd2;
      end
      default: begin
        beat_word      = pack8;
        beats_per_word = 3'd1;
      end
    endcase
  end

  // Next-state: layer control, packing, word completion and flush
  always_comb begin
    state_d    = state_q;
    prec_d     = prec_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    word_cnt_d = word_cnt_q;
    done_d     = 1'b0;
    acc_sum    = acc_q | (i_Vld ? beat_word : '0);
    cnt_after  = {1'b0, cnt_q} + {2'b00, i_Vld};
    do_write   = 1'b0;

    if (layer_start) begin
      // Start or restart: any partial word is dropped without a write
      state_d    = ACTIVE;
      prec_d     = (i_precision == 2'b11) ? PREC_8B : i_precision;
      ptr_d      = base_addr;
      acc_d      = '0;
      cnt_d      = 2'd0;
      word_cnt_d = '0;
    end else if (state_q == ACTIVE) begin
      // The beat is packed first; a coincident layer_end then flushes
      do_write = (cnt_after == beats_per_word) ||
                 (layer_end && (cnt_after != 3'd0));
      if (do_write) begin
        wr_en_d   = 1'b1;
        wr_addr_d = ptr_q;
        wr_data_d = acc_sum;
        ptr_d     = ptr_q + 1'b1;
        if (word_cnt_q != '1) begin
          word_cnt_d = word_cnt_q + 1'b1;
        end
      end
      if (do_write || layer_end) begin
        acc_d = '0;
        cnt_d = 2'd0;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_after[1:0];
      end
      if (layer_end) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      prec_q     <= PREC_8B;
      acc_q      <= '0;
      cnt_q      <= 2'd0;
      ptr_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      word_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prec_q     <= prec_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      word_cnt_q <= word_cnt_d;
      done_q     <= done_d;
    end
  end

  assign o_WrEn    = wr_en_q;
  assign o_WrAddr  = wr_addr_q;
  assign o_WrData  = wr_data_q;
  assign o_WordCnt = word_cnt_q;
  assign o_Busy    = (state_q == ACTIVE);
  assign o_Done    = done_q;

endmodule

// File: tb/tb_result_packer.sv
// tb_result_packer: directed scenarios for result_packer with hand-computed
// expected words, addresses and control flags.
module tb_result_packer;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         layer_start = 1'b0;
  logic [1:0]   i_precision = 2'd0;
  logic [11:0]  base_addr = 12'd0;
  logic         i_Vld = 1'b0;
  logic [127:0] i_Data = '0;
  logic         layer_end = 1'b0;
  logic         o_WrEn;
  logic [11:0]  o_WrAddr;
  logic [127:0] o_WrData;
  logic [12:0]  o_WordCnt;
  logic         o_Busy;
  logic         o_Done;

  int checks = 0;
  int failures = 0;

  result_packer #(.LANES(16), .LANE_WIDTH(8), .ADDR_WIDTH(12)) dut (
    .CLK(CLK), .RST(RST), .layer_start(layer_start), .i_precision(i_precision),
    .base_addr(base_addr), .i_Vld(i_Vld), .i_Data(i_Data), .layer_end(layer_end),
    .o_WrEn(o_WrEn), .o_WrAddr(o_WrAddr), .o_WrData(o_WrData),
    .o_WordCnt(o_WordCnt), .o_Busy(o_Busy), .o_Done(o_Done)
  );

  always #5 CLK = ~CLK;

  function automatic logic [127:0] fill(input logic [7:0] v);
    return {16{v}};
  endfunction

  // Advance one clock; outputs are then observed 1 time unit after the edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_layer(input logic [1:0] p, input logic [11:0] b);
    layer_start = 1'b1; i_precision = p; base_addr = b;
    i_Vld = 1'b0; layer_end = 1'b0;
    step();
    layer_start = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] flags;
    RST = 1'b1;
    step(); step();
    RST = 1'b0;
    flags = {o_WrEn, o_Done, o_Busy};
    checks++; if (flags !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", flags); end
    checks++; if (o_WrAddr !== 12'h000) begin failures++; $display("FAIL reset_addr got=%h exp=000", o_WrAddr); end
    checks++; if (o_WrData !== 128'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", o_WrData); end
    checks++; if (o_WordCnt !== 13'd0) begin failures++; $display("FAIL reset_wordcnt got=%0d exp=0", o_WordCnt); end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_8b_full();
    logic [127:0] ramp;
    logic [2:0]   flags, exp_flags;
    for (int k = 0; k < 16; k++) ramp[8*k +: 8] = 8'(k);
    start_layer(2'b10, 12'h010);
    checks++; if (o_Busy !== 1'b1) begin failures++; $display("FAIL 8b_busy_rise got=%b exp=1", o_Busy); end
    for (int j = 0; j < 3; j++) begin
      i_Vld = 1'b1; i_Data = ramp; layer_end = (j == 2);
      step();
      flags = {o_WrEn, o_Done, o_Busy};
      exp_flags = {1'b1, (j == 2), (j != 2)};
      checks++; if (flags !== exp_flags) begin failures++; $display("FAIL 8b_flags%0d got=%b exp=%b", j, flags, exp_flags); end
      checks++; if (o_WrAddr !== 12'h010 + 12'(j)) begin failures++; $display("FAIL 8b_addr%0d got=%h exp=%h", j, o_WrAddr, 12'h010 + 12'(j)); end
      checks++; if (o_WrData !== ramp) begin failures++; $display("FAIL 8b_data%0d got=%h exp=%h", j, o_WrData, ramp); end
    end
    checks++; if (o_WordCnt !== 13'd3) begin failures++; $display("FAIL 8b_wordcnt got=%0d exp=3", o_WordCnt); end
    i_Vld = 1'b0; layer_end = 1'b0;
    step();
    flags = {o_WrEn, o_Done, o_Busy};
    checks++; if (flags !== 3'b000) begin failures++; $display("FAIL 8b_after got=%b exp=000", flags); end
    $display("test_8b_full done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_2b_pack();
    logic [127:0] exp_word;
    logic [2:0]   flags, exp_flags;
    exp_word = {32'hFFFFFFFF, 32'hAAAAAAAA, 32'h55555555, 32'h0};
    start_layer(2'b00, 12'h020);
    for (int j = 0; j < 4; j++) begin
      // Upper lane bits set to 1 must not leak into the packed word
      i_Vld = 1'b1; i_Data = fill(8'hFC | 8'(j));
      step();
      flags = {o_WrEn, o_Done, o_Busy};
      exp_flags = {(j == 3), 1'b0, 1'b1};
      checks++; if (flags !== exp_flags) begin failures++; $display("FAIL 2b_flags%0d got=%b exp=%b", j, flags, exp_flags); end
    end
    checks++; if (o_WrAddr !== 12'h020) begin failures++; $display("FAIL 2b_addr got=%h exp=020", o_WrAddr); end
    checks++; if (o_WrData !== exp_word) begin failures++; $display("FAIL 2b_data got=%h exp=%h", o_WrData, exp_word); end
    i_Vld = 1'b0; layer_end = 1'b1;
    step();
    layer_end = 1'b0;
    flags = {o_WrEn, o_Done, o_Busy};
    checks++; if (flags !== 3'b010) begin failures++; $display("FAIL 2b_end_noflush got=%b exp=010", flags); end
    checks++; if (o_WordCnt !== 13'd1) begin failures++; $display("FAIL 2b_wordcnt got=%0d exp=1", o_WordCnt); end
    $display("test_2b_pack done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_4b_flush();
    logic [127:0] exp_part;
    logic [2:0]   flags, exp_flags;
    exp_part = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
    start_layer(2'b01, 12'h040);
    for (int j = 0; j < 3; j++) begin
      i_Vld = 1'b1; i_Data = fill(8'h0F);
      step();
      flags = {o_WrEn, o_Done, o_Busy};
      exp_flags = {(j == 1), 1'b0, 1'b1};
      checks++; if (flags !== exp_flags) begin failures++; $display("FAIL 4b_flags%0d got=%b exp=%b", j, flags, exp_flags); end
      if (j == 1) begin
        checks++; if (o_WrAddr !== 12'h040) begin failures++; $display("FAIL 4b_addr0 got=%h exp=040", o_WrAddr); end
        checks++; if (o_WrData !== {128{1'b1}}) begin failures++; $display("FAIL 4b_data0 got=%h exp=all-ones", o_WrData); end
      end
    end
    i_Vld = 1'b0; layer_end = 1'b1;
    step();
    layer_end = 1'b0;
    flags = {o_WrEn, o_Done, o_Busy};
    checks++; if (flags !== 3'b110) begin failures++; $display("FAIL 4b_flush_flags got=%b exp=110", flags); end
    checks++; if (o_WrAddr !== 12'h041) begin failures++; $display("FAIL 4b_addr1 got=%h exp=041", o_WrAddr); end
    checks++; if (o_WrData !== exp_part) begin failures++; $display("FAIL 4b_data1 got=%h exp=%h", o_WrData, exp_part); end
    checks++; if (o_WordCnt !== 13'd2) begin failures++; $display("FAIL 4b_wordcnt got=%0d exp=2", o_WordCnt); end
    $display("test_4b_flush done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_simultaneous();
    int         writes;
    logic [2:0] flags, exp_flags;
    writes = 0;
    start_layer(2'b00, 12'h080);
    for (int j = 0; j < 4; j++) begin
      i_Vld = 1'b1; i_Data = fill(8'h01); layer_end = (j == 3);
      step();
      if (o_WrEn === 1'b1) writes++;
      flags = {o_WrEn, o_Done, o_Busy};
      exp_flags = (j == 3) ? 3'b110 : 3'b001;
      checks++; if (flags !== exp_flags) begin failures++; $display("FAIL sim_flags%0d got=%b exp=%b", j, flags, exp_flags); end
    end
    checks++; if (o_WrAddr !== 12'h080) begin failures++; $display("FAIL sim_addr got=%h exp=080", o_WrAddr); end
    checks++; if (o_WrData !== {4{32'h55555555}}) begin failures++; $display("FAIL sim_data got=%h exp=%h", o_WrData, {4{32'h55555555}}); end
    i_Vld = 1'b0; layer_end = 1'b0;
    step();
    if (o_WrEn === 1'b1) writes++;
    checks++; if (writes != 1) begin failures++; $display("FAIL sim_write_count got=%0d exp=1", writes); end
    $display("test_simultaneous done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_wrap();
    logic [127:0] beat;
    logic [11:0]  exp_addr;
    logic [2:0]   flags, exp_flags;
    start_layer(2'b11, 12'hFFF);   // code 11 behaves as 8b
    for (int j = 0; j < 2; j++) begin
      beat = (j == 0) ? fill(8'hA5) : fill(8'h3C);
      i_Vld = 1'b1; i_Data = beat; layer_end = (j == 1);
      step();
      exp_addr = (j == 0) ? 12'hFFF : 12'h000;
      flags = {o_WrEn, o_Done, o_Busy};
      exp_flags = {1'b1, (j == 1), (j == 0)};
      checks++; if (flags !== exp_flags) begin failures++; $display("FAIL wrap_flags%0d got=%b exp=%b", j, flags, exp_flags); end
      checks++; if (o_WrAddr !== exp_addr) begin failures++; $display("FAIL wrap_addr%0d got=%h exp=%h", j, o_WrAddr, exp_addr); end
      checks++; if (o_WrData !== beat) begin failures++; $display("FAIL wrap_data%0d got=%h exp=%h", j, o_WrData, beat); end
    end
    i_Vld = 1'b0; layer_end = 1'b0;
    step();
    $display("test_wrap done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_restart();
    logic [127:0] exp_word;
    logic [2:0]   flags, exp_flags;
    exp_word = {32'hFFFFFFFF, 32'hAAAAAAAA, 32'h55555555, 32'h0};
    start_layer(2'b00, 12'h200);
    for (int j = 0; j < 2; j++) begin
      i_Vld = 1'b1; i_Data = fill(8'h03);
      step();
      flags = {o_WrEn, o_Done, o_Busy};
      checks++; if (flags !== 3'b001) begin failures++; $display("FAIL rst_old%0d got=%b exp=001", j, flags); end
    end
    // Restart with a beat presented in the same cycle: that beat is not taken
    layer_start = 1'b1; base_addr = 12'h100; i_precision = 2'b00; i_Data = fill(8'h03);
    step();
    layer_start = 1'b0;
    flags = {o_WrEn, o_Done, o_Busy};
    checks++; if (flags !== 3'b001) begin failures++; $display("FAIL rst_restart got=%b exp=001", flags); end
    for (int j = 0; j < 4; j++) begin
      i_Vld = 1'b1; i_Data = fill(8'(j));
      step();
      flags = {o_WrEn, o_Done, o_Busy};
      exp_flags = {(j == 3), 1'b0, 1'b1};
      checks++; if (flags !== exp_flags) begin failures++; $display("FAIL rst_new%0d got=%b exp=%b", j, flags, exp_flags); end
    end
    checks++; if (o_WrAddr !== 12'h100) begin failures++; $display("FAIL rst_addr got=%h exp=100", o_WrAddr); end
    checks++; if (o_WrData !== exp_word) begin failures++; $display("FAIL rst_data got=%h exp=%h", o_WrData, exp_word); end
    checks++; if (o_WordCnt !== 13'd1) begin failures++; $display("FAIL rst_wordcnt got=%0d exp=1", o_WordCnt); end
    i_Vld = 1'b0; layer_end = 1'b1;
    step();
    layer_end = 1'b0;
    $display("test_restart done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_reset_mid();
    logic [2:0] flags;
    start_layer(2'b10, 12'h300);
    i_Vld = 1'b1; i_Data = fill(8'h11);
    step();
    flags = {o_WrEn, o_Done, o_Busy};
    checks++; if (flags !== 3'b101) begin failures++; $display("FAIL rmid_pre got=%b exp=101", flags); end
    // Reset with a word-completing beat and layer_end pending
    i_Data = fill(8'h22); layer_end = 1'b1; RST = 1'b1;
    step();
    RST = 1'b0;
    flags = {o_WrEn, o_Done, o_Busy};
    checks++; if (flags !== 3'b000) begin failures++; $display("FAIL rmid_flags got=%b exp=000", flags); end
    checks++; if (o_WrAddr !== 12'h000) begin failures++; $display("FAIL rmid_addr got=%h exp=000", o_WrAddr); end
    checks++; if (o_WrData !== 128'h0) begin failures++; $display("FAIL rmid_data got=%h exp=0", o_WrData); end
    checks++; if (o_WordCnt !== 13'd0) begin failures++; $display("FAIL rmid_wordcnt got=%0d exp=0", o_WordCnt); end
    // In IDLE, layer_end and beats are ignored
    i_Vld = 1'b0; layer_end = 1'b1;
    step();
    flags = {o_WrEn, o_Done, o_Busy};
    checks++; if (flags !== 3'b000) begin failures++; $display("FAIL idle_end got=%b exp=000", flags); end
    layer_end = 1'b0; i_Vld = 1'b1;
    step();
    flags = {o_WrEn, o_Done, o_Busy};
    checks++; if (flags !== 3'b000) begin failures++; $display("FAIL idle_vld got=%b exp=000", flags); end
    i_Vld = 1'b0;
    $display("test_reset_mid done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    test_reset();
    test_8b_full();
    test_2b_pack();
    test_4b_flush();
    test_simultaneous();
    test_wrap();
    test_restart();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_packer.md
# result_packer

Packs the quantized activation beats produced by the result-quantization stage into full-width output-feature-map SRAM words and generates the write address, enable and layer-done signals. It sits directly downstream of the quantizer (its `i_Vld`/`i_Data` connect to the quantizer's `o_Vld`/`o_Data`) and directly upstream of the output buffer write port. Each beat carries 2-, 4- or 8-bit activations, so one SRAM word holds 4, 2 or 1 beats.

## Interface
- `LANES`, 16, activations per input beat
- `LANE_WIDTH`, 8, bits per lane in `i_Data`
- `ADDR_WIDTH`, 12, SRAM word-address width
- `CLK` in 1: single clock, all logic on rising edge
- `RST` in 1: reset, synchronous, active-high
- `layer_start` in 1: pulse; samples `i_precision` and `base_addr`, clears packing state
- `i_precision` in 2: next-layer activation precision; 00 = 2b, 01 = 4b, 10 = 8b, 11 treated as 8b
- `base_addr` in ADDR_WIDTH: first write address of the layer
- `i_Vld` in 1: input beat valid, no backpressure
- `i_Data` in LANES*LANE_WIDTH: lane k at [8k+7:8k], value in low p bits, upper bits ignored
- `layer_end` in 1: pulse; last beat has arrived, flush the partial word
- `o_WrEn` out 1: SRAM write strobe
- `o_WrAddr` out ADDR_WIDTH: write address
- `o_WrData` out LANES*LANE_WIDTH: packed word
- `o_WordCnt` out ADDR_WIDTH+1: words written since `layer_start`
- `o_Busy` out 1: high in ACTIVE
- `o_Done` out 1: one-cycle pulse at layer completion

## Operation
- States: IDLE, ACTIVE. IDLE -> ACTIVE on `layer_start`. ACTIVE -> IDLE on `layer_end`. `layer_start` in ACTIVE restarts the layer: the partial word is discarded without a write, and the pointer, beat counter and `o_WordCnt` reload.
- Beats per word B = 128/(16p): 4 at 2b, 2 at 4b, 1 at 8b. The precision register is frozen between `layer_start` events.
- Beat slot j (0..B-1) occupies word bits [j*16p +: 16p]. Within a slot, lane k's low p bits sit at offset k*p. Slot 0 is the first beat received.
- Beat counter counts 0..B-1. When the beat fills slot B-1, the word is written and the counter returns to 0. The accumulation register is cleared after every write.
- `layer_end` with counter > 0 writes the partial word with unfilled slots zero. With counter = 0 there is no write.
- `i_Vld` with `layer_end` in the same cycle: the beat is packed first, then the flush applies, so at most one write results.
- `i_Vld` in IDLE is ignored. `layer_end` in IDLE is ignored and produces no `o_Done`.
- Address starts at `base_addr` and increments by 1 after each write, wrapping modulo 2^ADDR_WIDTH.
- `o_WordCnt` increments on each write, saturating at all-ones.

## Timing
- Reset values: state IDLE; `o_WrEn`, `o_Done`, `o_Busy` = 0; `o_WrAddr`, `o_WrData`, `o_WordCnt` = 0. The accumulation register and beat counter are cleared.
- All outputs are registered.
- A beat completing a word at edge t produces `o_WrEn`=1 during cycle t+1, with `o_WrAddr`/`o_WrData` valid in that same cycle.
- `layer_end` at t produces `o_Done`=1 for exactly cycle t+1. The flush write, if any, is also in cycle t+1. `o_Busy` falls in t+1.
- `o_Busy` rises the cycle after `layer_start`. Beats are accepted starting the cycle after `layer_start`.
- Throughput: one beat per cycle sustained; `o_WrEn` is at most one per cycle.
- `RST` mid-layer: the next cycle is the reset state, with no write and no `o_Done`.

## Test plan
- **8b, full words:** `layer_start`, base 0x010, 3 beats with lane k = k, then `layer_end`.
  - 3 writes on consecutive cycles at 0x010..0x012.
  - Data bytes are 0x00..0x0F.
  - `o_Done` in the cycle of the last write; `o_WordCnt`=3.
- **2b packing:** 4 beats; beat j has all lanes = j.
  - One write with `o_WrData` = {32'hFFFFFFFF, 32'hAAAAAAAA, 32'h55555555, 32'h0}.
  - Upper lane bits set to 1 in the stimulus do not change the result.
- **4b partial flush:** 3 beats with all lanes = 4'hF, then `layer_end`.
  - Word 0 = all-ones at base.
  - Word 1 at base+1 = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}, with `o_Done` in the same cycle.
- **Simultaneous events:** 2b, 3 beats, then the 4th beat coincident with `layer_end`.
  - Exactly one write.
  - `o_Done` in the same cycle as that write.
- **Address wrap:** base = 0xFFF, 8b, 2 beats.
  - Writes at 0xFFF then 0x000.
- **Restart and reset:**
  - 2b, 2 beats, then `layer_start` with base 0x100, then 4 beats: a single write at 0x100 containing only the new beats.
  - `RST` asserted mid-layer: all outputs 0 the next cycle, with no write and no `o_Done`.
